data_path_param: RTL and testbench

Parametrised datapath for the multi-cycle CPU, driven cycle-by-cycle by the control unit. It provides a general-purpose register file in place of fixed A/B accumulators, plus a program counter, memory address register, stack pointer, instruction register and condition-code register. Widths are configurable, and the ALU is a parametrised sub-module. It sits between the control FSM and the byte-addressed memory.

---
 rtl/dp_pkg.sv | 29 ++
 rtl/alu_param.sv | 62 ++++++
 rtl/data_path_param.sv | 122 ++++++++++++
 tb/tb_data_path_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared encodings for the multi-cycle CPU datapath: ALU operations,
// bus source selects and condition-code bit positions.
package dp_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_INC = 3'b110;
  localparam logic [2:0] ALU_DEC = 3'b111;

  localparam logic [1:0] BUS1_PC   = 2'b00;
  localparam logic [1:0] BUS1_RS1  = 2'b01;
  localparam logic [1:0] BUS1_SP   = 2'b10;
  localparam logic [1:0] BUS1_ZERO = 2'b11;

  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;
  localparam logic [1:0] BUS2_ZERO = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_param.sv
// Combinational ALU: result truncated to DATA_W, NZVC computed alongside.
// C is carry-out for ADD/INC and borrow for SUB/DEC.
module alu_param
  import dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        nzvc
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] wide;
  logic            v;
  logic            c;

  always_comb begin
    wide = '0;
    v    = 1'b0;
    c    = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[DATA_W];
        v    = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // The extra top bit of a (DATA_W+1)-bit subtraction is the borrow.
        wide = {1'b0, a} - {1'b0, b};
        c    = wide[DATA_W];
        v    = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
      end
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      ALU_XOR: wide = {1'b0, a ^ b};
      ALU_NOT: wide = {1'b0, ~a};
      ALU_INC: begin
        wide = {1'b0, a} + (DATA_W + 1)'(1);
        c    = wide[DATA_W];
        v    = ~a[MSB] & wide[MSB];
      end
      ALU_DEC: begin
        wide = {1'b0, a} - (DATA_W + 1)'(1);
        c    = wide[DATA_W];
        v    = a[MSB] & ~wide[MSB];
      end
      default: wide = '0;
    endcase

    result         = wide[DATA_W-1:0];
    nzvc           = '0;
    nzvc[FLAG_N]   = wide[MSB];
    nzvc[FLAG_Z]   = (wide[DATA_W-1:0] == '0);
    nzvc[FLAG_V]   = v;
    nzvc[FLAG_C]   = c;
  end

endmodule

// File: rtl/data_path_param.sv
// Parametrised CPU datapath: register file, PC, SP, MAR, IR and CCR,
// two internal buses and an ALU, all sequenced by the external control FSM.
module data_path_param
  import dp_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int NREGS   = 4,
  parameter int SP_INIT = 2**ADDR_W - 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [DATA_W-1:0]        from_memory,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        to_memory,
  output logic [DATA_W-1:0]        IR_out,
  output logic [3:0]               CCR_Result,
  input  logic [2:0]               ALU_Sel,
  input  logic [1:0]               Bus1_Sel,
  input  logic [1:0]               Bus2_Sel,
  input  logic [$clog2(NREGS)-1:0] Rs1_Sel,
  input  logic [$clog2(NREGS)-1:0] Rs2_Sel,
  input  logic [$clog2(NREGS)-1:0] Rd_Sel,
  input  logic                     Reg_Load,
  input  logic                     IR_Load,
  input  logic                     MAR_Load,
  input  logic                     PC_Load,
  input  logic                     PC_Inc,
  input  logic                     CCR_Load,
  input  logic                     SP_Load,
  input  logic                     SP_Inc,
  input  logic                     SP_Dec
);

  localparam int IDX_W = $clog2(NREGS);

  logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [3:0]        ccr_q, ccr_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [DATA_W-1:0] rs1_data, rs2_data, bus1, bus2, alu_result;
  logic [3:0]        alu_nzvc;

  // Index compare per entry so indices >= NREGS naturally read as zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (Rs1_Sel == IDX_W'(i)) rs1_data = regs_q[i];
      if (Rs2_Sel == IDX_W'(i)) rs2_data = regs_q[i];
    end
  end

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .a       (rs1_data),
    .b       (rs2_data),
    .alu_sel (ALU_Sel),
    .result  (alu_result),
    .nzvc    (alu_nzvc)
  );

  always_comb begin
    case (Bus1_Sel)
      BUS1_PC:  bus1 = DATA_W'(pc_q);
      BUS1_RS1: bus1 = rs1_data;
      BUS1_SP:  bus1 = DATA_W'(sp_q);
      default:  bus1 = '0;
    endcase
    case (Bus2_Sel)
      BUS2_ALU:  bus2 = alu_result;
      BUS2_BUS1: bus2 = bus1;
      BUS2_MEM:  bus2 = from_memory;
      default:   bus2 = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (PC_Load)     pc_d = bus2[ADDR_W-1:0];
    else if (PC_Inc) pc_d = pc_q + ADDR_W'(1);

    sp_d = sp_q;
    if (SP_Load)                sp_d = bus2[ADDR_W-1:0];
    else if (SP_Inc && !SP_Dec) sp_d = sp_q + ADDR_W'(1);
    else if (SP_Dec && !SP_Inc) sp_d = sp_q - ADDR_W'(1);

    mar_d = MAR_Load ? bus2[ADDR_W-1:0] : mar_q;
    ir_d  = IR_Load  ? bus2 : ir_q;
    ccr_d = CCR_Load ? alu_nzvc : ccr_q;

    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (Reg_Load && (Rd_Sel == IDX_W'(i))) regs_d[i] = bus2;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q  <= '0;
      sp_q  <= ADDR_W'(SP_INIT);
      mar_q <= '0;
      ir_q  <= '0;
      ccr_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      mar_q  <= mar_d;
      ir_q   <= ir_d;
      ccr_q  <= ccr_d;
      regs_q <= regs_d;
    end
  end

  assign address    = mar_q;
  assign to_memory  = bus1;
  assign IR_out     = ir_q;
  assign CCR_Result = ccr_q;

endmodule

// File: tb/tb_data_path_param.sv
// Bench for data_path_param: directed scenarios plus a randomized run checked
// every cycle against an arithmetic model; a second 16/12/3 instance checks widths.
module tb_data_path_param;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // 8/8/4 instance
  logic [7:0] from_memory, address, to_memory, ir_out;
  logic [3:0] ccr_result;
  logic [2:0] alu_sel;
  logic [1:0] bus1_sel, bus2_sel, rs1_sel, rs2_sel, rd_sel;
  logic       reg_load, ir_load, mar_load, pc_load, pc_inc, ccr_load, sp_load, sp_inc, sp_dec;

  data_path_param dut (
    .Clk(clk), .Reset(rst_n), .from_memory(from_memory), .address(address),
    .to_memory(to_memory), .IR_out(ir_out), .CCR_Result(ccr_result),
    .ALU_Sel(alu_sel), .Bus1_Sel(bus1_sel), .Bus2_Sel(bus2_sel),
    .Rs1_Sel(rs1_sel), .Rs2_Sel(rs2_sel), .Rd_Sel(rd_sel),
    .Reg_Load(reg_load), .IR_Load(ir_load), .MAR_Load(mar_load),
    .PC_Load(pc_load), .PC_Inc(pc_inc), .CCR_Load(ccr_load),
    .SP_Load(sp_load), .SP_Inc(sp_inc), .SP_Dec(sp_dec)
  );

  // 16/12/3 instance
  logic [15:0] b_from, b_to, b_ir;
  logic [11:0] b_addr;
  logic [3:0]  b_ccr;
  logic [2:0]  b_alu_sel;
  logic [1:0]  b_bus1_sel, b_bus2_sel, b_rs1, b_rs2, b_rd;
  logic        b_reg_load, b_ir_load, b_mar_load, b_pc_load, b_pc_inc, b_ccr_load, b_sp_load, b_sp_inc, b_sp_dec;

  data_path_param #(.DATA_W(16), .ADDR_W(12), .NREGS(3)) dut_b (
    .Clk(clk), .Reset(rst_n), .from_memory(b_from), .address(b_addr),
    .to_memory(b_to), .IR_out(b_ir), .CCR_Result(b_ccr),
    .ALU_Sel(b_alu_sel), .Bus1_Sel(b_bus1_sel), .Bus2_Sel(b_bus2_sel),
    .Rs1_Sel(b_rs1), .Rs2_Sel(b_rs2), .Rd_Sel(b_rd),
    .Reg_Load(b_reg_load), .IR_Load(b_ir_load), .MAR_Load(b_mar_load),
    .PC_Load(b_pc_load), .PC_Inc(b_pc_inc), .CCR_Load(b_ccr_load),
    .SP_Load(b_sp_load), .SP_Inc(b_sp_inc), .SP_Dec(b_sp_dec)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input bit verbose);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else if (verbose) begin
      $display("[TB] %s = %0h ok", name, act);
    end
  endtask

  // ---------------- behavioural model (8/8/4) ----------------
  logic [7:0] m_pc, m_sp, m_mar, m_ir;
  logic [3:0] m_ccr;
  logic [7:0] m_r [4];
  bit         m_valid = 1'b0;

  // Returns {NZVC, result} using plain integer arithmetic.
  function automatic logic [11:0] m_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, u, s;
    logic c;
    logic [7:0] r;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    u = 0; s = 0; c = 1'b0;
    case (op)
      3'd0: begin u = ua + ub; s = sa + sb; c = (u > 255); end
      3'd1: begin u = ua - ub; s = sa - sb; c = (ua < ub); end
      3'd2: u = ua & ub;
      3'd3: u = ua | ub;
      3'd4: u = ua ^ ub;
      3'd5: u = 255 - ua;
      3'd6: begin u = ua + 1; s = sa + 1; c = (u > 255); end
      default: begin u = ua - 1; s = sa - 1; c = (ua == 0); end
    endcase
    r = u[7:0];
    return {r[7], (r == 8'd0), (s > 127 || s < -128), c, r};
  endfunction

  function automatic logic [7:0] m_bus1();
    case (bus1_sel)
      2'd0: return m_pc;
      2'd1: return m_r[rs1_sel];
      2'd2: return m_sp;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [11:0] al;
    logic [7:0]  b2;
    if (!rst_n) begin
      m_pc = 0; m_sp = 8'hFF; m_mar = 0; m_ir = 0; m_ccr = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      al = m_alu(alu_sel, m_r[rs1_sel], m_r[rs2_sel]);
      case (bus2_sel)
        2'd0: b2 = al[7:0];
        2'd1: b2 = m_bus1();
        2'd2: b2 = from_memory;
        default: b2 = 8'd0;
      endcase
      if (ccr_load) m_ccr = al[11:8];
      if (ir_load)  m_ir  = b2;
      if (mar_load) m_mar = b2;
      if (pc_load)     m_pc = b2;
      else if (pc_inc) m_pc = m_pc + 8'd1;
      if (sp_load)               m_sp = b2;
      else if (sp_inc != sp_dec) m_sp = sp_inc ? m_sp + 8'd1 : m_sp - 8'd1;
      if (reg_load) m_r[rd_sel] = b2;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("address", {24'd0, address}, {24'd0, m_mar}, 1'b0);
      check("IR_out", {24'd0, ir_out}, {24'd0, m_ir}, 1'b0);
      check("CCR_Result", {28'd0, ccr_result}, {28'd0, m_ccr}, 1'b0);
      check("to_memory", {24'd0, to_memory}, {24'd0, m_bus1()}, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {reg_load, ir_load, mar_load, pc_load, pc_inc, ccr_load, sp_load, sp_inc, sp_dec} = '0;
    alu_sel = 3'd0; bus2_sel = 2'd0;
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [7:0] v);
    clr(); bus2_sel = 2'd2; from_memory = v; reg_load = 1'b1; rd_sel = idx;
    tick(); clr();
  endtask

  task automatic load_pc(input logic [7:0] v);
    clr(); bus2_sel = 2'd2; from_memory = v; pc_load = 1'b1;
    tick(); clr();
  endtask

  task automatic load_sp(input logic [7:0] v);
    clr(); bus2_sel = 2'd2; from_memory = v; sp_load = 1'b1;
    tick(); clr();
  endtask

  task automatic peek(input string name, input logic [1:0] sel, input logic [1:0] rs, input logic [7:0] exp);
    bus1_sel = sel; rs1_sel = rs;
    #1;
    check(name, {24'd0, to_memory}, {24'd0, exp}, 1'b1);
  endtask

  task automatic b_clr();
    {b_reg_load, b_ir_load, b_mar_load, b_pc_load, b_pc_inc, b_ccr_load, b_sp_load, b_sp_inc, b_sp_dec} = '0;
  endtask

  task automatic b_peek(input string name, input logic [1:0] sel, input logic [1:0] rs, input logic [15:0] exp);
    b_bus1_sel = sel; b_rs1 = rs;
    #1;
    check(name, {16'd0, b_to}, {16'd0, exp}, 1'b1);
  endtask

  initial begin
    logic [11:0] pin;

    // Model pins: hand-computed ALU results.
    pin = m_alu(3'd0, 8'h7F, 8'h01); check("model_add_7f_01", {20'd0, pin}, 32'hA80, 1'b1);
    pin = m_alu(3'd1, 8'h05, 8'h05); check("model_sub_eq", {20'd0, pin}, 32'h400, 1'b1);
    pin = m_alu(3'd7, 8'h00, 8'h00); check("model_dec_0", {20'd0, pin}, 32'h9FF, 1'b1);
    pin = m_alu(3'd1, 8'h80, 8'h01); check("model_sub_ovf", {20'd0, pin}, 32'h27F, 1'b1);

    // Reset for two edges with every strobe high.
    rst_n = 1'b0; from_memory = 8'h5A; alu_sel = 3'd0;
    bus1_sel = 2'd0; bus2_sel = 2'd2; rs1_sel = 0; rs2_sel = 0; rd_sel = 0;
    {reg_load, ir_load, mar_load, pc_load, pc_inc, ccr_load, sp_load, sp_inc, sp_dec} = '1;
    b_from = 16'h1234; b_alu_sel = 3'd0; b_bus1_sel = 2'd0; b_bus2_sel = 2'd2;
    b_rs1 = 0; b_rs2 = 0; b_rd = 0;
    {b_reg_load, b_ir_load, b_mar_load, b_pc_load, b_pc_inc, b_ccr_load, b_sp_load, b_sp_inc, b_sp_dec} = '1;
    tick(); tick();
    rst_n = 1'b1; clr(); b_clr();
    check("rst_address", {24'd0, address}, 32'h0, 1'b1);
    check("rst_ir", {24'd0, ir_out}, 32'h0, 1'b1);
    check("rst_ccr", {28'd0, ccr_result}, 32'h0, 1'b1);
    peek("rst_pc", 2'd0, 2'd0, 8'h00);
    peek("rst_sp", 2'd2, 2'd0, 8'hFF);
    for (int i = 0; i < 4; i++) peek($sformatf("rst_r%0d", i), 2'd1, 2'(i), 8'h00);

    // Fetch
    load_pc(8'h10);
    bus1_sel = 2'd0; bus2_sel = 2'd1; mar_load = 1'b1; tick(); clr();
    check("fetch_address", {24'd0, address}, 32'h10, 1'b1);
    bus2_sel = 2'd2; from_memory = 8'hA5; ir_load = 1'b1; pc_inc = 1'b1; tick(); clr();
    check("fetch_ir", {24'd0, ir_out}, 32'hA5, 1'b1);
    peek("fetch_pc", 2'd0, 2'd0, 8'h11);

    // ALU flags
    load_reg(0, 8'h7F); load_reg(1, 8'h01);
    alu_sel = 3'd0; rs1_sel = 0; rs2_sel = 1; rd_sel = 2; reg_load = 1'b1; ccr_load = 1'b1;
    tick(); clr();
    check("add_ccr", {28'd0, ccr_result}, 32'hA, 1'b1);
    peek("add_r2", 2'd1, 2'd2, 8'h80);
    load_reg(0, 8'h05); load_reg(1, 8'h05);
    alu_sel = 3'd1; rs1_sel = 0; rs2_sel = 1; ccr_load = 1'b1; tick(); clr();
    check("sub_ccr", {28'd0, ccr_result}, 32'h4, 1'b1);
    load_reg(0, 8'h00);
    alu_sel = 3'd7; rs1_sel = 0; rd_sel = 3; reg_load = 1'b1; ccr_load = 1'b1; tick(); clr();
    check("dec_ccr", {28'd0, ccr_result}, 32'h9, 1'b1);
    peek("dec_r3", 2'd1, 2'd3, 8'hFF);

    // Wrap and priority
    load_pc(8'hFF); pc_inc = 1'b1; tick(); clr();
    peek("pc_wrap", 2'd0, 2'd0, 8'h00);
    bus2_sel = 2'd2; from_memory = 8'h40; pc_load = 1'b1; pc_inc = 1'b1; tick(); clr();
    peek("pc_load_prio", 2'd0, 2'd0, 8'h40);
    sp_inc = 1'b1; sp_dec = 1'b1; tick(); clr();
    peek("sp_inc_dec", 2'd2, 2'd0, 8'hFF);
    load_sp(8'h00); sp_dec = 1'b1; tick(); clr();
    peek("sp_dec_wrap", 2'd2, 2'd0, 8'hFF);

    // Read-during-write accumulation
    load_reg(0, 8'h03); load_reg(1, 8'h02);
    alu_sel = 3'd0; rs1_sel = 0; rs2_sel = 1; rd_sel = 0; reg_load = 1'b1; bus1_sel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rdw_r0_%0d", k), {24'd0, to_memory}, 32'(5 + 2 * k), 1'b1);
    end
    clr();

    // Wide instance: out-of-range index and address truncation
    b_peek("b_rst_sp", 2'd2, 2'd0, 16'h0FFF);
    for (int i = 0; i < 3; i++) begin
      b_bus2_sel = 2'd2; b_from = 16'(16'h1111 * (i + 1)); b_rd = 2'(i); b_reg_load = 1'b1;
      tick();
    end
    b_from = 16'hBEEF; b_rd = 2'd3; tick(); b_clr();
    b_peek("b_r3_reads_0", 2'd1, 2'd3, 16'h0000);
    for (int i = 0; i < 3; i++) b_peek($sformatf("b_r%0d", i), 2'd1, 2'(i), 16'(16'h1111 * (i + 1)));
    b_from = 16'hABCD; b_pc_load = 1'b1; tick(); b_clr();
    b_peek("b_pc", 2'd0, 2'd0, 16'h0BCD);
    b_bus2_sel = 2'd1; b_mar_load = 1'b1; tick(); b_clr();
    check("b_address", {20'd0, b_addr}, 32'hBCD, 1'b1);

    // Randomized run, checked every cycle by the model compare
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      from_memory = 8'($urandom); alu_sel = 3'($urandom);
      bus1_sel = 2'($urandom); bus2_sel = 2'($urandom);
      rs1_sel = 2'($urandom); rs2_sel = 2'($urandom); rd_sel = 2'($urandom);
      {reg_load, ir_load, mar_load, pc_load, pc_inc, ccr_load, sp_load, sp_inc, sp_dec} = 9'($urandom);
      tick();
    end
    rst_n = 1'b1; clr();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
